// File: rtl/im_mem_param.sv
// im_mem_param: parametrised instruction memory with registered fetch,
// byte-enabled writes, address error flag and a streaming program loader.
// All state changes on the falling edge of clk; reset is synchronous.
module im_mem_param #(
  parameter int                      DATA_W   = 32,
  parameter int                      DEPTH    = 16,
  parameter int                      ADDR_W   = 32,
  parameter logic [DEPTH*DATA_W-1:0] INIT     = '0,
  parameter logic [DATA_W-1:0]       NOP_WORD = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [ADDR_W-1:0]     pc,
  input  logic [DATA_W-1:0]     dataIn,
  input  logic [DATA_W/8-1:0]   byteEn,
  input  logic                  loadStart,
  input  logic                  loadValid,
  input  logic [DATA_W-1:0]     loadData,
  output logic [DATA_W-1:0]     IR,
  output logic                  irValid,
  output logic                  addrErr,
  output logic                  busy,
  output logic                  loadDone
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int BE_W  = DATA_W / 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  ptr;

  logic [IDX_W-1:0]  idx;
  logic              misaligned;
  logic              out_of_range;
  logic              addr_bad;
  logic              cpu_rd;
  logic              cpu_wr;
  logic              ld_wr;
  logic              ld_last;

  // Decode the byte address into a word index and its error conditions.
  always_comb begin
    idx          = pc[IDX_W+1:2];
    misaligned   = |pc[1:0];
    out_of_range = |pc[ADDR_W-1:IDX_W+2];
    addr_bad     = misaligned | out_of_range;
  end

  // Loader FSM next state plus the per-cycle access qualifiers it grants.
  always_comb begin
    state_nx = state;
    cpu_rd   = 1'b0;
    cpu_wr   = 1'b0;
    ld_wr    = 1'b0;
    ld_last  = 1'b0;
    case (state)
      IDLE: begin
        // A load request wins; the CPU access in the same cycle is dropped.
        if (loadStart) begin
          state_nx = LOAD;
        end else begin
          cpu_rd = memRead;
          cpu_wr = memWrite;
        end
      end
      LOAD: begin
        if (loadValid) begin
          ld_wr = 1'b1;
          if (ptr == LAST_IDX) begin
            ld_last  = 1'b1;
            state_nx = DONE;
          end else begin
            state_nx = LOAD;
          end
        end else begin
          state_nx = LOAD;
        end
      end
      DONE: begin
        // Fetches are served from the freshly loaded image; writes wait.
        cpu_rd   = memRead;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(negedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Storage array: reset image, loader words, or byte-enabled CPU writes.
  always_ff @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= INIT[i*DATA_W +: DATA_W];
      end
    end else if (ld_wr) begin
      mem[ptr] <= loadData;
    end else if (cpu_wr && !addr_bad) begin
      for (int k = 0; k < BE_W; k++) begin
        if (byteEn[k]) begin
          mem[idx][k*8 +: 8] <= dataIn[k*8 +: 8];
        end
      end
    end
  end

  // Registered fetch outputs, error flag, loader status and pointer.
  always_ff @(negedge clk) begin
    if (reset) begin
      IR       <= '0;
      irValid  <= 1'b0;
      addrErr  <= 1'b0;
      busy     <= 1'b0;
      loadDone <= 1'b0;
      ptr      <= '0;
    end else begin
      irValid  <= cpu_rd;
      loadDone <= ld_last;
      busy     <= (state_nx == LOAD);
      // Array reads see pre-edge contents, so a same-index write is read-before-write.
      if (cpu_rd) begin
        IR <= addr_bad ? NOP_WORD : mem[idx];
      end
      if (cpu_rd || cpu_wr) begin
        addrErr <= addr_bad;
      end
      if (ld_wr && !ld_last) begin
        ptr <= ptr + IDX_W'(1);
      end else if (ld_last || state != LOAD) begin
        ptr <= '0;
      end else begin
        ptr <= ptr;
      end
    end
  end

endmodule

// File: tb/tb_im_mem_param.sv
// Directed testbench for im_mem_param (DEPTH=16, DATA_W=32).
// Inputs change 1ns after each falling edge; outputs are checked at that
// same point, i.e. after the DUT's update edge and well before the next one.
module tb_im_mem_param;

  localparam logic [511:0] INIT_IMG = {{(14*32){1'b0}}, 32'h061BB088, 32'h000001E5};
  localparam logic [31:0]  NOP      = 32'h00000013;

  logic        clk;
  logic        reset;
  logic        memRead;
  logic        memWrite;
  logic [31:0] pc;
  logic [31:0] dataIn;
  logic [3:0]  byteEn;
  logic        loadStart;
  logic        loadValid;
  logic [31:0] loadData;
  logic [31:0] ir;
  logic        irValid;
  logic        addrErr;
  logic        busy;
  logic        loadDone;

  int n_cmp;
  int n_err;

  im_mem_param #(
    .DATA_W(32), .DEPTH(16), .ADDR_W(32), .INIT(INIT_IMG), .NOP_WORD(NOP)
  ) dut (
    .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite),
    .pc(pc), .dataIn(dataIn), .byteEn(byteEn), .loadStart(loadStart),
    .loadValid(loadValid), .loadData(loadData), .IR(ir), .irValid(irValid),
    .addrErr(addrErr), .busy(busy), .loadDone(loadDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    memRead = 1'b0; memWrite = 1'b0; pc = 32'h0; dataIn = 32'h0;
    byteEn = 4'h0; loadStart = 1'b0; loadValid = 1'b0; loadData = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (ir !== 32'h0) begin n_err++; $display("FAIL reset_ir: got %h want %h", ir, 32'h0); end
    n_cmp++; if (irValid !== 1'b0) begin n_err++; $display("FAIL reset_irvalid: got %b want 0", irValid); end
    n_cmp++; if (addrErr !== 1'b0) begin n_err++; $display("FAIL reset_addrerr: got %b want 0", addrErr); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (loadDone !== 1'b0) begin n_err++; $display("FAIL reset_loaddone: got %b want 0", loadDone); end
  endtask

  task automatic test_fetch();
    memRead = 1'b1; pc = 32'h0;
    step();
    n_cmp++; if (ir !== 32'h000001E5) begin n_err++; $display("FAIL fetch0_ir: got %h want %h", ir, 32'h000001E5); end
    n_cmp++; if (irValid !== 1'b1) begin n_err++; $display("FAIL fetch0_irvalid: got %b want 1", irValid); end
    n_cmp++; if (addrErr !== 1'b0) begin n_err++; $display("FAIL fetch0_addrerr: got %b want 0", addrErr); end
    pc = 32'h4;
    step();
    n_cmp++; if (ir !== 32'h061BB088) begin n_err++; $display("FAIL fetch1_ir: got %h want %h", ir, 32'h061BB088); end
    n_cmp++; if (irValid !== 1'b1) begin n_err++; $display("FAIL fetch1_irvalid: got %b want 1", irValid); end
    memRead = 1'b0; pc = 32'h0;
    step();
    n_cmp++; if (ir !== 32'h061BB088) begin n_err++; $display("FAIL fetch_hold_ir: got %h want %h", ir, 32'h061BB088); end
    n_cmp++; if (irValid !== 1'b0) begin n_err++; $display("FAIL fetch_hold_irvalid: got %b want 0", irValid); end
  endtask

  task automatic test_byte_write();
    memWrite = 1'b1; pc = 32'h8; dataIn = 32'hAABBCCDD; byteEn = 4'b0101;
    step();
    n_cmp++; if (irValid !== 1'b0) begin n_err++; $display("FAIL bw_irvalid: got %b want 0", irValid); end
    memWrite = 1'b0; memRead = 1'b1; byteEn = 4'h0;
    step();
    n_cmp++; if (ir !== 32'h00BB00DD) begin n_err++; $display("FAIL bw_read: got %h want %h", ir, 32'h00BB00DD); end
    memRead = 1'b0;
  endtask

  task automatic test_addr_err();
    memRead = 1'b1; pc = 32'h42;
    step();
    n_cmp++; if (ir !== NOP) begin n_err++; $display("FAIL misalign_ir: got %h want %h", ir, NOP); end
    n_cmp++; if (addrErr !== 1'b1) begin n_err++; $display("FAIL misalign_err: got %b want 1", addrErr); end
    n_cmp++; if (irValid !== 1'b1) begin n_err++; $display("FAIL misalign_irvalid: got %b want 1", irValid); end
    pc = 32'h0;
    step();
    n_cmp++; if (addrErr !== 1'b0) begin n_err++; $display("FAIL clear_err: got %b want 0", addrErr); end
    pc = 32'h40;
    step();
    n_cmp++; if (ir !== NOP) begin n_err++; $display("FAIL range_ir: got %h want %h", ir, NOP); end
    n_cmp++; if (addrErr !== 1'b1) begin n_err++; $display("FAIL range_err: got %b want 1", addrErr); end
    pc = 32'h0;
    step();
    n_cmp++; if (ir !== 32'h000001E5) begin n_err++; $display("FAIL after_err_ir: got %h want %h", ir, 32'h000001E5); end
    n_cmp++; if (addrErr !== 1'b0) begin n_err++; $display("FAIL after_err_clear: got %b want 0", addrErr); end
    // Out-of-range write aliasing onto word 1 must not change the array.
    memRead = 1'b0; memWrite = 1'b1; pc = 32'h44; dataIn = 32'hCAFEF00D; byteEn = 4'hF;
    step();
    n_cmp++; if (addrErr !== 1'b1) begin n_err++; $display("FAIL badwr_err: got %b want 1", addrErr); end
    memWrite = 1'b0; memRead = 1'b1; pc = 32'h4; byteEn = 4'h0;
    step();
    n_cmp++; if (ir !== 32'h061BB088) begin n_err++; $display("FAIL badwr_nochange: got %h want %h", ir, 32'h061BB088); end
    n_cmp++; if (addrErr !== 1'b0) begin n_err++; $display("FAIL badwr_clear: got %b want 0", addrErr); end
    memRead = 1'b0;
  endtask

  task automatic test_rw_same();
    memRead = 1'b1; memWrite = 1'b1; pc = 32'h4; dataIn = 32'h12345678; byteEn = 4'hF;
    step();
    n_cmp++; if (ir !== 32'h061BB088) begin n_err++; $display("FAIL rw_old: got %h want %h", ir, 32'h061BB088); end
    memWrite = 1'b0; byteEn = 4'h0;
    step();
    n_cmp++; if (ir !== 32'h12345678) begin n_err++; $display("FAIL rw_new: got %h want %h", ir, 32'h12345678); end
    memRead = 1'b0;
  endtask

  task automatic test_load();
    int done_pulses;
    int bad_status;
    done_pulses = 0;
    bad_status  = 0;
    memRead = 1'b1; pc = 32'h3C; loadStart = 1'b1;
    step();
    loadStart = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL load_start_busy: got %b want 1", busy); end
    n_cmp++; if (irValid !== 1'b0) begin n_err++; $display("FAIL load_start_irvalid: got %b want 0", irValid); end
    for (int i = 0; i < 16; i++) begin
      if ((i % 4) == 1) begin
        loadValid = 1'b0;
        step();
        if (busy !== 1'b1 || irValid !== 1'b0 || loadDone !== 1'b0) bad_status++;
      end
      loadValid = 1'b1;
      loadData  = 32'h11111111 * i;
      step();
      if (loadDone === 1'b1) done_pulses++;
      if (i < 15) begin
        if (busy !== 1'b1 || irValid !== 1'b0) bad_status++;
      end else begin
        n_cmp++; if (loadDone !== 1'b1) begin n_err++; $display("FAIL load_done_pulse: got %b want 1", loadDone); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL load_done_busy: got %b want 0", busy); end
      end
    end
    n_cmp++; if (bad_status !== 0) begin n_err++; $display("FAIL load_status: got %0d bad cycles want 0", bad_status); end
    loadValid = 1'b0;
    step();
    if (loadDone === 1'b1) done_pulses++;
    n_cmp++; if (ir !== 32'hFFFFFFFF) begin n_err++; $display("FAIL load_read15: got %h want %h", ir, 32'hFFFFFFFF); end
    n_cmp++; if (irValid !== 1'b1) begin n_err++; $display("FAIL load_read_irvalid: got %b want 1", irValid); end
    n_cmp++; if (done_pulses !== 1) begin n_err++; $display("FAIL load_done_count: got %0d want 1", done_pulses); end
    pc = 32'h8;
    step();
    n_cmp++; if (ir !== 32'h22222222) begin n_err++; $display("FAIL load_read2: got %h want %h", ir, 32'h22222222); end
    memRead = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    loadStart = 1'b1;
    step();
    loadStart = 1'b0;
    for (int i = 0; i < 5; i++) begin
      loadValid = 1'b1;
      loadData  = 32'hDEAD0000 + i;
      step();
    end
    loadValid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midload_busy: got %b want 1", busy); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midload_reset_busy: got %b want 0", busy); end
    memRead = 1'b1; pc = 32'h0;
    step();
    n_cmp++; if (ir !== 32'h000001E5) begin n_err++; $display("FAIL midload_word0: got %h want %h", ir, 32'h000001E5); end
    n_cmp++; if (irValid !== 1'b1) begin n_err++; $display("FAIL midload_idle: got %b want 1", irValid); end
    pc = 32'h4;
    step();
    n_cmp++; if (ir !== 32'h061BB088) begin n_err++; $display("FAIL midload_word1: got %h want %h", ir, 32'h061BB088); end
    memRead = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_fetch();
    test_byte_write();
    test_addr_err();
    test_rw_same();
    test_load();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
